nx_node_instr_store: RTL

//  Instruction memory for one node; sits directly upstream of the node core.

---
 rtl/nx_node_instr_store_pkg.sv | 11 +
 rtl/nx_node_instr_store_ram.sv | 36 +++
 rtl/nx_node_instr_store.sv | 87 ++++++++
 3 files changed

// File: rtl/nx_node_instr_store_pkg.sv
// Shared types and sizing for the node instruction store.
// Instruction type, its width, and RAM depth/address width.
package nx_node_instr_store_pkg;

    typedef logic [14:0] nx_instruction_t;

    localparam int NX_INSTR_WIDTH = $bits(nx_instruction_t);
    localparam int NX_MAX_INSTRS  = 512;
    localparam int NX_ADDR_W      = $clog2(NX_MAX_INSTRS);

endpackage

// File: rtl/nx_node_instr_store_ram.sv
// Single-port RAM: one read or write per cycle, registered read data.
// Ports: clk, rst_n, addr, we, wdata, re, rdata (held when no read).
module nx_node_instr_store_ram #(
    parameter int DEPTH  = 512,
    parameter int WIDTH  = 15,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage itself is never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read data holds its value unless a read is performed, so the
    // consumer can replay the last result across a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/nx_node_instr_store.sv
// Node instruction store: appends loaded instructions, serves core fetch.
// Ports: clk_i, rst_i (async low), load_clear/valid/data/ready,
// populated_o, overflow_o, fetch_addr/rd/data/stall.
// Option NX_INSTR_STORE_FETCH_PRIO_EN: fetch wins the RAM port.
module nx_node_instr_store
    import nx_node_instr_store_pkg::*;
#(
    parameter int MAX_INSTRS  = NX_MAX_INSTRS,
    parameter int INSTR_WIDTH = NX_INSTR_WIDTH,
    parameter int ADDR_W      = $clog2(MAX_INSTRS)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   load_clear_i,
    input  logic                   load_valid_i,
    input  logic [INSTR_WIDTH-1:0] load_data_i,
    output logic                   load_ready_o,
    output logic [ADDR_W-1:0]      populated_o,
    output logic                   overflow_o,
    input  logic [ADDR_W-1:0]      fetch_addr_i,
    input  logic                   fetch_rd_i,
    output logic [INSTR_WIDTH-1:0] fetch_data_o,
    output logic                   fetch_stall_o
);

    logic [ADDR_W-1:0] populated;
    logic              overflow;
    logic              full;
    logic              load_acc;
    logic              rd_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] ram_addr;

    // One entry is never used: the core halts when pc == populated.
    assign full = (populated == ADDR_W'(MAX_INSTRS - 1));

`ifdef NX_INSTR_STORE_FETCH_PRIO_EN
    assign load_ready_o  = (!full || load_clear_i) && !fetch_rd_i;
    assign fetch_stall_o = 1'b0;
    assign rd_en         = fetch_rd_i;
`else
    assign load_ready_o  = !full || load_clear_i;
    assign fetch_stall_o = fetch_rd_i && load_acc;
    assign rd_en         = fetch_rd_i && !load_acc;
`endif

    assign load_acc = load_valid_i && load_ready_o;

    // A clear restarts the append pointer, even for a load in the same cycle.
    assign wr_addr  = load_clear_i ? '0 : populated;
    assign ram_addr = load_acc ? wr_addr : fetch_addr_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            populated <= '0;
            overflow  <= 1'b0;
        end else if (load_clear_i) begin
            populated <= load_acc ? ADDR_W'(1) : '0;
            overflow  <= 1'b0;
        end else begin
            if (load_acc) begin
                populated <= populated + ADDR_W'(1);
            end
            if (load_valid_i && full) begin
                overflow <= 1'b1;
            end
        end
    end

    nx_node_instr_store_ram #(
        .DEPTH  (MAX_INSTRS),
        .WIDTH  (INSTR_WIDTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk_i),
        .rst_n (rst_i),
        .addr  (ram_addr),
        .we    (load_acc),
        .wdata (load_data_i),
        .re    (rd_en),
        .rdata (fetch_data_o)
    );

    assign populated_o = populated;
    assign overflow_o  = overflow;

endmodule
